// File: rtl/rc_nrzi_unstuff.sv
`default_nettype none
// ============================================================================
//  Module   : rc_nrzi_unstuff
//  Function : NRZI decoder and bit unstuffer for the receive path, with
//             stuff-violation and packet-length checking.
//  Revision : 1.0  initial release
// ============================================================================
module rc_nrzi_unstuff #(
  parameter int CNT_W    = 7,
  parameter int MAX_BITS = 88
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in,
  input  logic             in_valid,
  input  logic             start_in,
  input  logic             end_in,
  input  logic             abort,
  output logic             d_out,
  output logic             d_valid,
  output logic             pkt_start,
  output logic             pkt_end,
  output logic             stuff_err,
  output logic             len_err,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       ONES_MAX = 3'd6;

  logic [1:0]       state, state_nxt;
  logic             prev_level, prev_nxt;
  logic [2:0]       ones_cnt, ones_nxt;
  logic [CNT_W-1:0] bit_count_nxt;
  logic             d_out_nxt, d_valid_nxt, pkt_start_nxt, pkt_end_nxt;
  logic             stuff_err_nxt, len_err_nxt;

  logic dec, bit_in_recv, at_six, full;
  logic stuffed, stuff_bad, len_bad, deliver_ok, bit_err;

  // Bit qualification: abort and start_in both pre-empt any bit in the same cycle
  assign dec         = ~(s_in ^ prev_level);
  assign bit_in_recv = (state == ST_RECV) && in_valid && !start_in && !abort;
  assign at_six      = (ones_cnt == ONES_MAX);
  assign full        = (bit_count == MAX_CNT);
  assign stuffed     = bit_in_recv && at_six && !dec;
  assign stuff_bad   = bit_in_recv && at_six && dec;
  assign deliver_ok  = bit_in_recv && !at_six && !full;
  assign len_bad     = bit_in_recv && !at_six && full;
  assign bit_err     = stuff_bad || len_bad;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      prev_level <= 1'b0;
      ones_cnt   <= 3'd0;
      bit_count  <= '0;
      d_out      <= 1'b0;
      d_valid    <= 1'b0;
      pkt_start  <= 1'b0;
      pkt_end    <= 1'b0;
      stuff_err  <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_level <= prev_nxt;
      ones_cnt   <= ones_nxt;
      bit_count  <= bit_count_nxt;
      d_out      <= d_out_nxt;
      d_valid    <= d_valid_nxt;
      pkt_start  <= pkt_start_nxt;
      pkt_end    <= pkt_end_nxt;
      stuff_err  <= stuff_err_nxt;
      len_err    <= len_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else if (start_in) begin
      state_nxt = ST_RECV;
    end else begin
      case (state)
        ST_RECV: begin
          if (bit_err) begin
            state_nxt = ST_ERROR;
          end else if (end_in) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_ERROR: begin
          if (end_in) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    prev_nxt      = prev_level;
    ones_nxt      = ones_cnt;
    bit_count_nxt = bit_count;
    d_out_nxt     = 1'b0;
    d_valid_nxt   = 1'b0;
    pkt_start_nxt = 1'b0;
    pkt_end_nxt   = 1'b0;
    stuff_err_nxt = 1'b0;
    len_err_nxt   = 1'b0;
    if (abort) begin
      prev_nxt      = 1'b0;
      ones_nxt      = 3'd0;
      bit_count_nxt = '0;
    end else if (start_in) begin
      // SYNC always ends in K, so decoding restarts from level 0
      prev_nxt      = 1'b0;
      ones_nxt      = 3'd0;
      bit_count_nxt = '0;
      pkt_start_nxt = 1'b1;
    end else if (state == ST_RECV) begin
      if (in_valid) begin
        prev_nxt = s_in;
      end
      if (stuffed) begin
        ones_nxt = 3'd0;
      end else if (deliver_ok) begin
        d_out_nxt     = dec;
        d_valid_nxt   = 1'b1;
        ones_nxt      = dec ? ones_cnt + 3'd1 : 3'd0;
        bit_count_nxt = bit_count + CNT_ONE;
      end
      stuff_err_nxt = stuff_bad;
      len_err_nxt   = len_bad;
      pkt_end_nxt   = end_in && !bit_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rc_nrzi_unstuff.sv
`default_nettype none
// Testbench for rc_nrzi_unstuff: directed scenarios with literal expectations
// plus randomized traffic checked cycle-by-cycle against a behavioural model.
module tb_rc_nrzi_unstuff;
  localparam int CNT_W    = 7;
  localparam int MAX_BITS = 88;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_in = 1'b0, in_valid = 1'b0, start_in = 1'b0, end_in = 1'b0, abort = 1'b0;
  logic d_out, d_valid, pkt_start, pkt_end, stuff_err, len_err;
  logic [CNT_W-1:0] bit_count;

  int total = 0;
  int bad = 0;

  // Behavioural model: packet-level status, line level and run of decoded ones
  bit m_active, m_err, m_level;
  int m_ones, m_count;
  bit e_dout, e_dv, e_ps, e_pe, e_se, e_le;

  // Observed-output log used by the directed checks
  int dv_cnt, ps_cnt, pe_cnt, se_cnt, le_cnt;
  logic [127:0] dv_bits;

  rc_nrzi_unstuff #(.CNT_W(CNT_W), .MAX_BITS(MAX_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .in_valid(in_valid),
    .start_in(start_in), .end_in(end_in), .abort(abort),
    .d_out(d_out), .d_valid(d_valid), .pkt_start(pkt_start), .pkt_end(pkt_end),
    .stuff_err(stuff_err), .len_err(len_err), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_log();
    dv_cnt = 0; ps_cnt = 0; pe_cnt = 0; se_cnt = 0; le_cnt = 0; dv_bits = '0;
  endtask

  // Model step and per-cycle compare
  always @(posedge clk) begin
    bit d, err_now;
    e_dout = 0; e_dv = 0; e_ps = 0; e_pe = 0; e_se = 0; e_le = 0;
    if (!rst_n || abort) begin
      m_active = 0; m_err = 0; m_level = 0; m_ones = 0; m_count = 0;
    end else if (start_in) begin
      m_active = 1; m_err = 0; m_level = 0; m_ones = 0; m_count = 0; e_ps = 1;
    end else if (m_active) begin
      err_now = 0;
      if (in_valid) begin
        d = (s_in == m_level);
        m_level = s_in;
        if (m_ones == 6) begin
          if (d) begin e_se = 1; err_now = 1; end
          else m_ones = 0;
        end else if (m_count == MAX_BITS) begin
          e_le = 1; err_now = 1;
        end else begin
          e_dv = 1; e_dout = d; m_count++;
          m_ones = d ? m_ones + 1 : 0;
        end
      end
      if (err_now) begin
        m_active = 0; m_err = 1;
      end else if (end_in) begin
        e_pe = 1; m_active = 0;
      end
    end else if (m_err && end_in) begin
      m_err = 0;
    end
    #1;
    check("d_valid", d_valid, e_dv);
    if (e_dv) check("d_out", d_out, e_dout);
    check("pkt_start", pkt_start, e_ps);
    check("pkt_end", pkt_end, e_pe);
    check("stuff_err", stuff_err, e_se);
    check("len_err", len_err, e_le);
    check("bit_count", bit_count, m_count);
    if (d_valid) begin dv_cnt++; dv_bits = {dv_bits[126:0], d_out}; end
    if (pkt_start) ps_cnt++;
    if (pkt_end) pe_cnt++;
    if (stuff_err) se_cnt++;
    if (len_err) le_cnt++;
  end

  task automatic drive(input logic iv, input logic s, input logic st, input logic en, input logic ab);
    @(negedge clk);
    in_valid = iv; s_in = s; start_in = st; end_in = en; abort = ab;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic send_levels(input logic [127:0] lv, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1, lv[i], 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones_pct, endp, r;
    logic lvl;
    clear_log();
    idle(3);
    check("rst_outputs", {d_out, d_valid, pkt_start, pkt_end, stuff_err, len_err}, 0);
    check("rst_count", bit_count, 0);
    rst_n = 1'b1;
    idle(2);

    // Decode: K,K,J,J,K -> 1,1,0,1,0
    clear_log();
    drive(0, 0, 1, 0, 0);
    send_levels(128'b00110, 5);
    drive(0, 0, 0, 1, 0);
    idle(2);
    check("dec_ps", ps_cnt, 1);
    check("dec_dv", dv_cnt, 5);
    check("dec_bits", int'(dv_bits[4:0]), 5'b11010);
    check("dec_pe", pe_cnt, 1);
    check("dec_count", bit_count, 5);

    // Unstuff: K x6, J (stuffed), K -> 1111110
    clear_log();
    drive(0, 0, 1, 0, 0);
    send_levels(128'b00000010, 8);
    drive(0, 0, 0, 1, 0);
    idle(2);
    check("stf_dv", dv_cnt, 7);
    check("stf_bits", int'(dv_bits[6:0]), 7'b1111110);
    check("stf_count", bit_count, 7);
    check("stf_err", se_cnt, 0);
    check("stf_pe", pe_cnt, 1);

    // Stuff error: K x7
    clear_log();
    drive(0, 0, 1, 0, 0);
    send_levels(128'b0000000, 7);
    drive(0, 0, 0, 1, 0);
    idle(2);
    check("se_dv", dv_cnt, 6);
    check("se_err", se_cnt, 1);
    check("se_pe", pe_cnt, 0);

    // Length: 89 decoded zeros (level toggles every bit)
    clear_log();
    drive(0, 0, 1, 0, 0);
    lvl = 1'b0;
    for (int i = 0; i < 89; i++) begin lvl = ~lvl; drive(1, lvl, 0, 0, 0); end
    for (int i = 0; i < 4; i++) begin lvl = ~lvl; drive(1, lvl, 0, 0, 0); end
    idle(2);
    check("len_dv", dv_cnt, 88);
    check("len_err", le_cnt, 1);
    check("len_count", bit_count, 88);
    drive(0, 0, 0, 1, 0);
    idle(2);
    check("len_pe", pe_cnt, 0);

    // Last bit together with end_in
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0);
    @(posedge clk); #2;
    check("sim_dv", d_valid, 1);
    check("sim_pe", pkt_end, 1);
    check("sim_dout", d_out, 0);

    // Abort with in_valid and end_in
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 1);
    @(posedge clk); #2;
    check("ab_dv", d_valid, 0);
    check("ab_pe", pkt_end, 0);
    check("ab_count", bit_count, 0);

    // Reset mid-packet
    drive(0, 0, 1, 0, 0);
    send_levels(128'b0101100110, 10);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", {d_out, d_valid, pkt_start, pkt_end, stuff_err, len_err}, 0);
    check("mid_rst_count", bit_count, 0);
    @(negedge clk); rst_n = 1'b1;
    clear_log();
    send_levels(128'b00101, 5);
    idle(2);
    check("post_rst_dv", dv_cnt, 0);

    // Randomized traffic
    ones_pct = 80; endp = 30; lvl = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      logic st, ab, en, iv, s;
      r  = int'($urandom_range(0, 999));
      st = (r < 15);
      ab = (r >= 15 && r < 20);
      en = !st && (int'($urandom_range(0, 999)) < endp);
      iv = ($urandom_range(0, 99) < 70);
      s  = ($urandom_range(0, 99) < ones_pct) ? lvl : ~lvl;
      if (iv) lvl = s;
      if (st) begin
        case ($urandom_range(0, 2))
          0: begin ones_pct = 85; endp = 30; end
          1: begin ones_pct = 50; endp = 20; end
          default: begin ones_pct = 20; endp = 2; end
        endcase
      end
      drive(iv, s, st, en, ab);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
